// File: rtl/mem_access_pkg.sv
// mem_access_pkg: FSM states, RV32I load/store funct3 codes and access-size decode
// shared by mem_access_unit and load_store_align.
package mem_access_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bytes touched by an access; 0 marks a funct3 that is never legal.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        return (funct3 == F3_B || funct3 == F3_BU) ? 3'd1 :
               (funct3 == F3_H || funct3 == F3_HU) ? 3'd2 :
               (funct3 == F3_W) ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational load extension and byte/halfword store merge
// for a big-endian RAM whose read word starts at the addressed byte.
module load_store_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_rdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data  = funct3 == F3_B  ? {{24{ram_rdata[31]}}, ram_rdata[31:24]} :
                     funct3 == F3_BU ? {24'd0, ram_rdata[31:24]} :
                     funct3 == F3_H  ? {{16{ram_rdata[31]}}, ram_rdata[31:16]} :
                     funct3 == F3_HU ? {16'd0, ram_rdata[31:16]} :
                     funct3 == F3_W  ? ram_rdata : 32'd0;
        merge_data = funct3 == F3_B ? {wdata[7:0], ram_rdata[23:0]} :
                     funct3 == F3_H ? {wdata[15:0], ram_rdata[15:0]} : wdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a zero-delay byte-addressed RAM.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [dataW-1:0]       req_wdata,
    output logic                   rsp_valid,
    output logic [dataW-1:0]       rsp_rdata,
    output logic                   rsp_err,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       RAMDataOut,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMDataIn
);

    localparam logic [32:0] RAM_MAX_ADDR = 33'((64'd1 << RAMAddrSize) - 64'd1);

    state_t      state, next_state;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merge_q, load_data, merge_data;
    logic [2:0]  size;
    logic        misalign, err;

    load_store_align u_align (
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .ram_rdata  (RAMDataIn),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign = (size == 3'd2 && addr_q[0]) || (size == 3'd4 && addr_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Error flag is derived from the latched request, so it stays valid through RESP.
    always_comb begin
        size = access_size(f3_q);
        err  = size == 3'd0 || (write_q && f3_q[2]) || misalign ||
               ({1'b0, addr_q} + 33'(size) - 33'd1 > RAM_MAX_ADDR);
        next_state = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
                     state == ACCESS ? ((err || !write_q || f3_q == F3_W) ? RESP : WRITE) :
                     state == WRITE  ? RESP : IDLE;
        RAMWriteControl = !err && (state == WRITE || (state == ACCESS && write_q && f3_q == F3_W));
        RAMDataOut      = !RAMWriteControl ? '0 : state == WRITE ? merge_q : wdata_q;
    end

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_err   = rsp_valid && err;
    assign RAMAddr   = addr_q[RAMAddrSize-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q   <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                write_q <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACCESS) begin
                rsp_rdata <= (err || write_q) ? '0 : load_data;
                merge_q   <= merge_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a byte-array
// reference model; honours MEM_ACCESS_MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] RAMAddr;
    logic [31:0] RAMDataOut, RAMDataIn;
    logic        RAMWriteControl;

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int          total = 0, passed = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    mem_access_unit dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .RAMAddr         (RAMAddr),
        .RAMDataOut      (RAMDataOut),
        .RAMWriteControl (RAMWriteControl),
        .RAMDataIn       (RAMDataIn)
    );

    always #5 clock = ~clock;

    // Zero-delay big-endian RAM that wraps at the top of its address space.
    always_comb RAMDataIn = {ram[RAMAddr], ram[RAMAddr + 16'd1], ram[RAMAddr + 16'd2], ram[RAMAddr + 16'd3]};
    always @(posedge clock)
        if (RAMWriteControl)
            for (int k = 0; k < 4; k++) ram[RAMAddr + 16'(k)] <= RAMDataOut[31 - 8*k -: 8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int model_size(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    // Architectural meaning of one access, from the reference memory.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  output logic e, output logic [31:0] rd, output int lat);
        int  sz   = model_size(f3);
        bit  legal = w ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                       : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        longint last = longint'(a) + longint'(sz) - 1;
        int  v = 0;
        e = !legal || last > 65535;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (a % sz != 0) e = 1'b1;
`endif
        if (!e && !w) begin
            for (int k = 0; k < sz; k++) v = (v << 8) | int'(ref_mem[(a + k) & 32'hFFFF]);
            if (f3[2] == 1'b0) v = (v << (32 - 8*sz)) >>> (32 - 8*sz);
        end
        rd  = (e || w) ? 32'd0 : 32'(v);
        lat = (!e && w && sz < 4) ? 3 : 2;
    endfunction

    task automatic set_bytes(input logic [15:0] a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            ram[a + 16'(k)]     = v[31 - 8*k -: 8];
            ref_mem[a + 16'(k)] = v[31 - 8*k -: 8];
        end
    endtask

    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic e, got = 1'b0, seen_wc = 1'b0, bad_ready = 1'b0;
        logic [31:0] rd;
        int lat, n = 0, sz;
        model(w, f3, a, e, rd, lat);
        @(negedge clock);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (n < 6 && !got) begin
            @(negedge clock);
            n++;
            if (RAMWriteControl) seen_wc = 1'b1;
            if (req_ready) bad_ready = 1'b1;
            if (rsp_valid) begin
                got = 1'b1;
                last_rdata = rsp_rdata;
                last_err = rsp_err;
            end
        end
        check("rsp_latency", 32'(n), 32'(lat));
        check("rsp_rdata", last_rdata, rd);
        check("rsp_err", {31'd0, last_err}, {31'd0, e});
        check("ready_low_busy", {31'd0, bad_ready}, 32'd0);
        if (e) check("no_write_on_err", {31'd0, seen_wc}, 32'd0);
        if (!e && w) begin
            sz = model_size(f3);
            for (int k = 0; k < sz; k++) ref_mem[(a + k) & 32'hFFFF] = wd[8*(sz - 1 - k) +: 8];
        end
        @(negedge clock);
        check("rsp_one_cycle", {30'd0, rsp_valid, req_ready}, 32'd1);
        for (int k = 0; k < 5; k++)
            check("mem_window", {24'd0, ram[a[15:0] + 16'(k)]}, {24'd0, ref_mem[a[15:0] + 16'(k)]});
    endtask

    initial begin
        logic [31:0] ra;
        int mism = 0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        #12;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_outputs", {rsp_valid, rsp_err, RAMWriteControl}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_ramaddr", {16'd0, RAMAddr}, 32'd0);
        check("reset_dataout", RAMDataOut, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        set_bytes(16'h0010, 32'h807F1234);
        txn(1'b0, 3'b000, 32'h10, 32'd0); check("lb_lit", last_rdata, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'h10, 32'd0); check("lbu_lit", last_rdata, 32'h00000080);
        txn(1'b0, 3'b001, 32'h10, 32'd0); check("lh_lit", last_rdata, 32'hFFFF807F);
        txn(1'b0, 3'b010, 32'h10, 32'd0); check("lw_lit", last_rdata, 32'h807F1234);

        set_bytes(16'h0020, 32'hAABBCCDD);
        txn(1'b1, 3'b000, 32'h21, 32'h55);
        check("sb_rmw_lit", {ram[16'h20], ram[16'h21], ram[16'h22], ram[16'h23]}, 32'hAA55CCDD);

        txn(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        txn(1'b0, 3'b010, 32'h40, 32'd0); check("sw_lw_lit", last_rdata, 32'hDEADBEEF);

        txn(1'b0, 3'b011, 32'h40, 32'd0); check("illegal_f3_err", {31'd0, last_err}, 32'd1);
        txn(1'b1, 3'b010, 32'hFFFD, 32'h12345678); check("range_err", {31'd0, last_err}, 32'd1);

        txn(1'b0, 3'b010, 32'h41, 32'd0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check("misalign_lw_err", {31'd0, last_err}, 32'd1);
`else
        check("misalign_lw_data", last_rdata, {8'hAD, 8'hBE, 8'hEF, ram[16'h44]});
`endif

        // Reset while the SH write-back is pending must drop the write.
        set_bytes(16'h0080, 32'h11223344);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h80; req_wdata = 32'hBEEF;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("sh_in_write", {31'd0, RAMWriteControl}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_wc", {31'd0, RAMWriteControl}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("abort_mem", {ram[16'h80], ram[16'h81], ram[16'h82], ram[16'h83]}, 32'h11223344);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'(16'hFFF8 + 16'($urandom_range(0, 7)));
                1: ra = $urandom;
                default: ra = 32'($urandom_range(0, 255));
            endcase
            txn(1'($urandom), 3'($urandom), ra, $urandom);
        end

        for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("final_mem", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
